// File: rtl/round_sequencer_pkg.sv
// round_sequencer_pkg: shared state type, widths and LFSR taps for the number game
package round_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int NUM_W = 8;
  localparam int TIME_W = 5;
  localparam int LEVEL_W = 8;
  localparam logic [NUM_W-1:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/round_sequencer_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, never reaches zero from a non-zero seed
module lfsr8
  import round_sequencer_pkg::*;
#(
  parameter logic [NUM_W-1:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  output logic [NUM_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= SEED;
    else q <= {q[NUM_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: per-round target draw, level-scaled countdown and guess/timeout resolution
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int BASE_TIME = 30,
  parameter int MIN_TIME = 3,
  parameter logic [NUM_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               guess_b,
  input  logic [NUM_W-1:0]   sw_i,
  output logic [NUM_W-1:0]   target_o,
  output logic [TIME_W-1:0]  time_left_o,
  output logic               busy_o,
  output logic               cmp_r,
  output logic               end_f,
  output logic               done_o
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [NUM_W-1:0] lfsr;
  logic guess_q, guess_edge, tick, last_tick;
  logic [9:0] lvl2, t_full;
  logic [TIME_W-1:0] round_t;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  assign guess_edge = guess_b & ~guess_q;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign last_tick = tick && time_left_o == TIME_W'(1);
  // Round time saturates at MIN_TIME once 2*level eats the whole margin
  assign lvl2 = {1'b0, level_i, 1'b0};
  assign t_full = lvl2 >= 10'(BASE_TIME - MIN_TIME) ? 10'(MIN_TIME) : 10'(BASE_TIME) - lvl2;
  assign round_t = t_full[TIME_W-1:0];
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = start_i ? LOAD : IDLE;
      LOAD: state_n = RUN;
      RUN:  state_n = (guess_edge || last_tick) ? DONE : RUN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      guess_q <= 1'b0;
      target_o <= '0;
      time_left_o <= '0;
      busy_o <= 1'b0;
      cmp_r <= 1'b0;
      end_f <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      guess_q <= guess_b;
      busy_o <= state_n == LOAD || state_n == RUN;
      done_o <= state_n == DONE;
      presc <= (state == RUN && !tick) ? presc + 1'b1 : '0;
      if (state == IDLE && start_i) begin
        cmp_r <= 1'b0;
        end_f <= 1'b0;
      end
      if (state == LOAD) begin
        target_o <= lfsr;
        time_left_o <= round_t;
      end
      // A guess edge takes priority over a coincident final tick
      if (state == RUN) begin
        if (guess_edge) begin
          cmp_r <= sw_i == target_o;
          end_f <= 1'b0;
        end else if (tick) begin
          time_left_o <= time_left_o - 1'b1;
          if (last_tick) begin
            end_f <= 1'b1;
            cmp_r <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed and randomized rounds checked against a behavioural model
module tb_round_sequencer;
  localparam int TD = 4;
  localparam int BT = 30;
  localparam int MT = 3;
  logic clk = 0, rst = 0, start_i = 0, guess_b = 0;
  logic [7:0] level_i = 0, sw_i = 0, target_o;
  logic [4:0] time_left_o;
  logic busy_o, cmp_r, end_f, done_o;
  logic [7:0] mlfsr, exp_target;
  int passed = 0, total = 0;
  round_sequencer #(.TICK_DIV(TD), .BASE_TIME(BT), .MIN_TIME(MT), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .level_i(level_i), .guess_b(guess_b), .sw_i(sw_i),
    .target_o(target_o), .time_left_o(time_left_o), .busy_o(busy_o), .cmp_r(cmp_r),
    .end_f(end_f), .done_o(done_o));
  always #5 clk = ~clk;
  always @(posedge clk)
    mlfsr <= rst ? 8'hA5 : {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  function automatic int round_time(input int lvl);
    return 2 * lvl >= BT - MT ? MT : BT - 2 * lvl;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int lvl);
    level_i = 8'(lvl);
    start_i = 1;
    tick();
    start_i = 0;
    exp_target = mlfsr;
    tick();
    check("run_target", 32'(target_o), 32'(exp_target));
    check("run_time", 32'(time_left_o), 32'(round_time(lvl)));
    check("run_busy", 32'(busy_o), 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_target"}, 32'(target_o), 0);
    check({tag, "_time"}, 32'(time_left_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_cmp"}, 32'(cmp_r), 0);
    check({tag, "_end"}, 32'(end_f), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_lfsr"}, 32'(dut.u_lfsr.q), 32'h A5);
  endtask
  initial begin
    int t, w, m, distinct;
    logic [7:0] sw, v;
    bit seen [256];
    rst = 1;
    tick();
    rst = 0;
    check_reset_outputs("reset");
    do_start(0);
    for (int j = 0; j < BT * TD; j++) begin
      check("countdown", 32'(time_left_o), 32'(BT - j / TD));
      check("no_done_yet", 32'(done_o), 0);
      tick();
    end
    check("timeout_done", 32'(done_o), 1);
    check("timeout_end", 32'(end_f), 1);
    check("timeout_cmp", 32'(cmp_r), 0);
    check("timeout_time", 32'(time_left_o), 0);
    tick();
    check("timeout_idle_done", 32'(done_o), 0);
    check("timeout_idle_busy", 32'(busy_o), 0);
    check("timeout_hold_end", 32'(end_f), 1);
    foreach (seen[i]) seen[i] = 0;
    for (int r = 0; r < 14; r++) begin
      int lvl;
      lvl = r == 0 ? 14 : r == 1 ? 200 : r == 2 ? 13 : r == 3 ? 0 : $urandom_range(0, 255);
      t = round_time(lvl);
      do_start(lvl);
      w = $urandom_range(0, t * TD - 1);
      repeat (w) tick();
      check("pre_guess_time", 32'(time_left_o), 32'(t - w / TD));
      m = r < 4 ? r % 2 : $urandom_range(0, 1);
      sw = m ? exp_target : (r < 4 ? exp_target ^ 8'h01 : 8'($urandom));
      sw_i = sw;
      guess_b = 1;
      tick();
      check("guess_done", 32'(done_o), 1);
      check("guess_cmp", 32'(cmp_r), 32'(sw == exp_target));
      check("guess_end", 32'(end_f), 0);
      guess_b = 0;
      tick();
      check("guess_idle_done", 32'(done_o), 0);
      check("guess_idle_busy", 32'(busy_o), 0);
      check("guess_hold_cmp", 32'(cmp_r), 32'(sw == exp_target));
    end
    guess_b = 1;
    tick();
    tick();
    do_start(13);
    repeat (3) tick();
    check("held_no_done", 32'(done_o), 0);
    check("held_busy", 32'(busy_o), 1);
    guess_b = 0;
    tick();
    sw_i = exp_target;
    guess_b = 1;
    tick();
    check("repress_done", 32'(done_o), 1);
    check("repress_cmp", 32'(cmp_r), 1);
    guess_b = 0;
    tick();
    do_start(14);
    repeat (MT * TD - 1) tick();
    check("final_tick_time", 32'(time_left_o), 1);
    sw_i = exp_target ^ 8'h80;
    guess_b = 1;
    tick();
    check("final_guess_done", 32'(done_o), 1);
    check("final_guess_end", 32'(end_f), 0);
    check("final_guess_cmp", 32'(cmp_r), 0);
    guess_b = 0;
    tick();
    do_start(0);
    repeat (2) tick();
    start_i = 1;
    tick();
    start_i = 0;
    check("start_in_run_busy", 32'(busy_o), 1);
    tick();
    check("start_in_run_time", 32'(time_left_o), 32'(BT - 1));
    check("start_in_run_target", 32'(target_o), 32'(exp_target));
    rst = 1;
    tick();
    rst = 0;
    check_reset_outputs("mid_rst");
    distinct = 0;
    for (int i = 0; i < 255; i++) begin
      v = dut.u_lfsr.q;
      check("lfsr_model", 32'(v), 32'(mlfsr));
      check("lfsr_nonzero", 32'(v != 0), 1);
      if (!seen[v]) distinct++;
      seen[v] = 1;
      tick();
    end
    check("lfsr_distinct", 32'(distinct), 255);
    check("lfsr_wrap", 32'(dut.u_lfsr.q), 32'h A5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
